// File: rtl/minmax_pkg.sv
// Shared constants and helpers for the pipelined min/max reduction tree.
package minmax_pkg;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    // Width of an element index; never narrower than one bit.
    function automatic int index_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/minmax_node.sv
// Combinational two-input compare/select used at every node of the tree.
// The left input always carries the lower element index.
module minmax_node
    import minmax_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IW     = 2,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] left_val,
    input  logic [IW-1:0]    left_idx,
    input  logic [WIDTH-1:0] right_val,
    input  logic [IW-1:0]    right_idx,
    input  logic             mode,
    output logic [WIDTH-1:0] win_val,
    output logic [IW-1:0]    win_idx
);

    logic right_less;
    logic right_greater;
    logic take_right;

    // Strict comparisons so equal values keep the left (lower-index) element.
    always_comb begin
        if (SIGNED != 0) begin
            right_less    = $signed(right_val) < $signed(left_val);
            right_greater = $signed(right_val) > $signed(left_val);
        end else begin
            right_less    = right_val < left_val;
            right_greater = right_val > left_val;
        end
        take_right = (mode == MODE_MAX) ? right_greater : right_less;
        win_val    = take_right ? right_val : left_val;
        win_idx    = take_right ? right_idx : left_idx;
    end

endmodule

// File: rtl/minmax_tree.sv
// Pipelined N-input min/max selector: one registered binary-reduction level
// per tree depth, a single shared stall enable, and the winning index.
module minmax_tree
    import minmax_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  N      = 4,
    parameter int  SIGNED = 0,
    localparam int IW     = index_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IW-1:0]      out_idx,
    output logic               out_mode
);

    localparam int LEVELS = $clog2(N);

    logic en;

    // The whole pipe moves together unless a finished result is being held.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
        localparam int CNT_IN = (N + (1 << s) - 1) >> s;
        localparam int CNT    = (N + (1 << (s + 1)) - 1) >> (s + 1);

        logic [WIDTH-1:0] src_val  [CNT_IN];
        logic [IW-1:0]    src_idx  [CNT_IN];
        logic             src_mode;
        logic             src_valid;
        logic [WIDTH-1:0] win_val  [CNT];
        logic [IW-1:0]    win_idx  [CNT];
        logic [WIDTH-1:0] node_val [CNT];
        logic [IW-1:0]    node_idx [CNT];
        logic             node_mode;
        logic             node_valid;

        if (s == 0) begin : g_src
            for (genvar k = 0; k < CNT_IN; k++) begin : g_el
                assign src_val[k] = in_data[k*WIDTH +: WIDTH];
                assign src_idx[k] = IW'(k);
            end
            assign src_mode  = in_mode;
            assign src_valid = in_valid;
        end else begin : g_src
            for (genvar k = 0; k < CNT_IN; k++) begin : g_el
                assign src_val[k] = g_lvl[s-1].node_val[k];
                assign src_idx[k] = g_lvl[s-1].node_idx[k];
            end
            assign src_mode  = g_lvl[s-1].node_mode;
            assign src_valid = g_lvl[s-1].node_valid;
        end

        for (genvar j = 0; j < CNT; j++) begin : g_node
            if (2*j + 1 < CNT_IN) begin : g_pair
                minmax_node #(
                    .WIDTH  (WIDTH),
                    .IW     (IW),
                    .SIGNED (SIGNED)
                ) u_node (
                    .left_val  (src_val[2*j]),
                    .left_idx  (src_idx[2*j]),
                    .right_val (src_val[2*j+1]),
                    .right_idx (src_idx[2*j+1]),
                    .mode      (src_mode),
                    .win_val   (win_val[j]),
                    .win_idx   (win_idx[j])
                );
            end else begin : g_pass
                assign win_val[j] = src_val[2*j];
                assign win_idx[j] = src_idx[2*j];
            end
        end

        // Level register: clears on reset, holds while stalled, otherwise advances.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                node_valid <= 1'b0;
                node_mode  <= 1'b0;
                for (int j = 0; j < CNT; j++) begin
                    node_val[j] <= '0;
                    node_idx[j] <= '0;
                end
            end else if (en) begin
                node_valid <= src_valid;
                node_mode  <= src_mode;
                for (int j = 0; j < CNT; j++) begin
                    node_val[j] <= win_val[j];
                    node_idx[j] <= win_idx[j];
                end
            end
        end
    end

    assign out_valid = g_lvl[LEVELS-1].node_valid;
    assign out_data  = g_lvl[LEVELS-1].node_val[0];
    assign out_idx   = g_lvl[LEVELS-1].node_idx[0];
    assign out_mode  = g_lvl[LEVELS-1].node_mode;

endmodule

// File: tb/tb_minmax_tree.sv
// Self-checking bench for minmax_tree: three instances (N=4 unsigned,
// N=4 signed, N=5 unsigned) checked every cycle against a queue-based model.
module tb_minmax_tree;
    import minmax_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  imode;
    logic [31:0] d4u;
    logic [31:0] d4s;
    logic [39:0] d5;
    logic [2:0]  ird;
    logic [2:0]  ov;
    logic [2:0]  omode;
    logic [7:0]  od0, od1, od2;
    logic [1:0]  oi_u, oi_s;
    logic [2:0]  oi_5;

    int checks = 0;
    int errors = 0;
    int rst_count = 0;
    int hs [3];

    logic [7:0] p_val  [3][8];
    int         p_idx  [3][8];
    logic       p_mode [3][8];
    int         p_rem  [3][8];
    int         p_cnt  [3];

    minmax_tree #(.WIDTH(8), .N(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ird[0]),
        .in_data(d4u), .in_mode(imode[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_data(od0), .out_idx(oi_u), .out_mode(omode[0])
    );

    minmax_tree #(.WIDTH(8), .N(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ird[1]),
        .in_data(d4s), .in_mode(imode[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_data(od1), .out_idx(oi_s), .out_mode(omode[1])
    );

    minmax_tree #(.WIDTH(8), .N(5), .SIGNED(0)) dut_5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ird[2]),
        .in_data(d5), .in_mode(imode[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_data(od2), .out_idx(oi_5), .out_mode(omode[2])
    );

    // Free-running clock.
    initial forever #5 clk = ~clk;

    // Count reset assertions so the model can discard in-flight work.
    initial forever begin
        @(negedge rst_n);
        rst_count++;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got no finish required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int lev_of(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int n_of(input int d);
        return (d == 2) ? 5 : 4;
    endfunction

    function automatic bit sgn_of(input int d);
        return d == 1;
    endfunction

    function automatic logic [7:0] dut_data(input int d);
        return (d == 0) ? od0 : (d == 1) ? od1 : od2;
    endfunction

    function automatic int dut_idx(input int d);
        return (d == 0) ? 32'(oi_u) : (d == 1) ? 32'(oi_s) : 32'(oi_5);
    endfunction

    // Linear scan over the elements: strictly better values replace the current pick.
    task automatic model_pick(input logic [39:0] bus, input int n, input bit sgn,
                              input logic mode, output logic [7:0] v, output int idx);
        int best;
        int cur;
        logic [7:0] e;
        v    = bus[7:0];
        idx  = 0;
        best = sgn ? int'($signed(v)) : int'(v);
        for (int k = 1; k < n; k++) begin
            e   = bus[k*8 +: 8];
            cur = sgn ? int'($signed(e)) : int'(e);
            if ((mode == MODE_MAX) ? (cur > best) : (cur < best)) begin
                best = cur;
                v    = e;
                idx  = k;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one vector on DUT d and hold it until it is accepted.
    task automatic applyStimulus(input int d, input logic [39:0] data, input logic mode);
        bit accepted;
        int guard;
        accepted = 1'b0;
        guard    = 0;
        iv[d]    = 1'b1;
        imode[d] = mode;
        case (d)
            0:       d4u = data[31:0];
            1:       d4s = data[31:0];
            default: d5  = data;
        endcase
        while (!accepted && guard < 50) begin
            @(negedge clk);
            accepted = ird[d];
            @(posedge clk);
            #1;
            guard++;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout dut%0d got no accept required accept", d);
        end
        iv[d] = 1'b0;
    endtask

    // Single vector on an idle pipe with hand-computed result and latency.
    task automatic runOne(input int d, input logic [39:0] data, input logic mode,
                          input logic [7:0] ev, input int ei, input int lat, input string tag);
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(d, data, mode);
        for (int i = 0; i < lat - 1; i++) begin
            @(negedge clk);
            checkOutput({tag, "_early_valid"}, 32'(ov[d]), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(ov[d]), 32'd1);
        checkOutput({tag, "_data"}, 32'(dut_data(d)), 32'(ev));
        checkOutput({tag, "_idx"}, dut_idx(d), ei);
    endtask

    // Per-cycle compare against the model, then advance the model for the coming edge.
    initial begin : compare_proc
        logic [7:0]  ev;
        int          ei;
        logic [39:0] bus;
        logic        mv;
        logic        me;
        int          rst_seen;
        rst_seen = 0;
        for (int d = 0; d < 3; d++) begin
            p_cnt[d] = 0;
            hs[d]    = 0;
        end
        forever begin
            @(negedge clk);
            if (rst_count != rst_seen || !rst_n) begin
                rst_seen = rst_count;
                for (int d = 0; d < 3; d++) p_cnt[d] = 0;
            end
            for (int d = 0; d < 3; d++) begin
                mv = (p_cnt[d] > 0) && (p_rem[d][0] == 0);
                me = !mv || ordy[d];
                checkOutput($sformatf("dut%0d_in_ready", d), 32'(ird[d]), 32'(me));
                checkOutput($sformatf("dut%0d_out_valid", d), 32'(ov[d]), 32'(mv));
                if (mv) begin
                    checkOutput($sformatf("dut%0d_out_data", d), 32'(dut_data(d)), 32'(p_val[d][0]));
                    checkOutput($sformatf("dut%0d_out_idx", d), dut_idx(d), p_idx[d][0]);
                    checkOutput($sformatf("dut%0d_out_mode", d), 32'(omode[d]), 32'(p_mode[d][0]));
                end
                if (ov[d] && ordy[d]) hs[d]++;
                if (rst_n && me) begin
                    if (mv) begin
                        for (int k = 0; k < p_cnt[d] - 1; k++) begin
                            p_val[d][k]  = p_val[d][k+1];
                            p_idx[d][k]  = p_idx[d][k+1];
                            p_mode[d][k] = p_mode[d][k+1];
                            p_rem[d][k]  = p_rem[d][k+1];
                        end
                        p_cnt[d]--;
                    end
                    for (int k = 0; k < p_cnt[d]; k++) begin
                        if (p_rem[d][k] > 0) p_rem[d][k]--;
                    end
                    if (iv[d] && p_cnt[d] < 8) begin
                        bus = (d == 0) ? {8'h00, d4u} : (d == 1) ? {8'h00, d4s} : d5;
                        model_pick(bus, n_of(d), sgn_of(d), imode[d], ev, ei);
                        p_val[d][p_cnt[d]]  = ev;
                        p_idx[d][p_cnt[d]]  = ei;
                        p_mode[d][p_cnt[d]] = imode[d];
                        p_rem[d][p_cnt[d]]  = lev_of(d) - 1;
                        p_cnt[d]++;
                    end
                end
            end
        end
    end

    initial begin : main_proc
        int hs0;
        int guard;
        iv    = 3'b000;
        ordy  = 3'b111;
        imode = 3'b000;
        d4u   = '0;
        d4s   = '0;
        d5    = '0;

        // Reset state, observed while reset is still asserted.
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("rst_valid%0d", d), 32'(ov[d]), 32'd0);
            checkOutput($sformatf("rst_data%0d", d), 32'(dut_data(d)), 32'd0);
            checkOutput($sformatf("rst_idx%0d", d), dut_idx(d), 0);
            checkOutput($sformatf("rst_mode%0d", d), 32'(omode[d]), 32'd0);
            checkOutput($sformatf("rst_ready%0d", d), 32'(ird[d]), 32'd1);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Minimum with a tie: lowest index of the minima wins.
        runOne(0, 40'h00_03_09_03_05, MODE_MIN, 8'd3, 1, 2, "min4");

        // Maximum followed back-to-back by an all-equal vector.
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(0, 40'h00_00_FF_11_C8, MODE_MAX);
        applyStimulus(0, 40'h00_00_00_00_00, MODE_MAX);
        @(negedge clk);
        checkOutput("max4_data", 32'(od0), 32'hFF);
        checkOutput("max4_idx", dut_idx(0), 2);
        checkOutput("max4_mode", 32'(omode[0]), 32'd1);
        @(negedge clk);
        checkOutput("zero4_valid", 32'(ov[0]), 32'd1);
        checkOutput("zero4_data", 32'(od0), 32'h00);
        checkOutput("zero4_idx", dut_idx(0), 0);

        // Signedness on the same element bits.
        runOne(1, 40'h00_7F_80_01_FF, MODE_MIN, 8'h80, 2, 2, "smin");
        runOne(0, 40'h00_7F_80_01_FF, MODE_MIN, 8'h01, 1, 2, "umin");
        runOne(1, 40'h00_7F_80_01_FF, MODE_MAX, 8'h7F, 3, 2, "smax");

        // Backpressure: six vectors, three stall cycles after the first result.
        repeat (4) @(posedge clk);
        #1;
        hs0 = hs[0];
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(0, {8'd0, 8'd50, 8'(3*i), 8'(10-i), 8'(i+1)}, i[0]);
                end
            end
            begin
                guard = 0;
                while (!ov[0] && guard < 40) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                ordy[0] = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bp_in_ready_stall", 32'(ird[0]), 32'd0);
                    checkOutput("bp_valid_stall", 32'(ov[0]), 32'd1);
                    @(posedge clk);
                    #1;
                end
                ordy[0] = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        checkOutput("bp_delivered", 32'(hs[0] - hs0), 32'd6);

        // Reset in the middle of two in-flight vectors.
        repeat (4) @(posedge clk);
        #1;
        applyStimulus(0, 40'h00_01_02_03_04, MODE_MIN);
        applyStimulus(0, 40'h00_04_03_02_01, MODE_MAX);
        #1;
        checkOutput("pre_rst_valid", 32'(ov[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(ov[0]), 32'd0);
        checkOutput("mid_rst_data", 32'(od0), 32'd0);
        checkOutput("mid_rst_idx", dut_idx(0), 0);
        checkOutput("mid_rst_mode", 32'(omode[0]), 32'd0);
        checkOutput("mid_rst_ready", 32'(ird[0]), 32'd1);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("post_rst_no_result", 32'(ov[0]), 32'd0);
        end
        runOne(0, 40'h00_06_08_02_04, MODE_MIN, 8'd2, 1, 2, "post_rst");

        // Odd element count: pass-through node and three levels.
        runOne(2, 40'h01_07_07_07_07, MODE_MIN, 8'd1, 4, 3, "n5_min_last");
        runOne(2, 40'h07_07_07_07_07, MODE_MIN, 8'd7, 0, 3, "n5_min_tie");
        runOne(2, 40'h09_09_09_09_01, MODE_MAX, 8'd9, 1, 3, "n5_max_tie");

        repeat (6) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
